pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for pll_locked; legal range 2..4.
REQ-002 Parameter PLL_RST_CYCLES, default 16: refclk cycles pll_rst is held high per PLL reset; legal range 2..255.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before sys_rst_n release; legal range 2..65535.
REQ-004 Parameter LOCK_TIMEOUT, default 65535: maximum refclk cycles to wait for lock before re-resetting the PLL; legal range 2..65535.
REQ-005 refclk  input  1  free-running 50 MHz reference clock; the only clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 pll_locked  input  1  PLL lock indicator; asynchronous to refclk.
REQ-008 pll_rst  output  1  active-high reset to the PLL rst port.
REQ-009 sys_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-010 state  output  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN.
REQ-011 lock_lost_cnt  output  8  RUN-to-PLL_RESET transitions; saturates at 255.
REQ-012 timeout_cnt  output  8  WAIT_LOCK timeouts; saturates at 255.

Function
REQ-013 pll_locked SHALL pass through SYNC_STAGES refclk flops, yielding locked_s; only locked_s SHALL be used.
REQ-014 All outputs SHALL be registered; pll_rst is 1 exactly in PLL_RESET, and sys_rst_n is 1 exactly in RUN, both changing on the same edge as state.
REQ-015 A single cycle counter SHALL clear to 0 on every state transition and increment once per cycle otherwise.
REQ-016 PLL_RESET SHALL last exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK, regardless of locked_s.
REQ-017 In WAIT_LOCK, locked_s=1 SHALL go to STABLE; otherwise, after LOCK_TIMEOUT cycles in WAIT_LOCK, go to PLL_RESET and increment timeout_cnt.
REQ-018 When locked_s=1 and the timeout occur in the same cycle, lock SHALL win: go to STABLE, timeout_cnt unchanged.
REQ-019 In STABLE, locked_s=0 SHALL go to WAIT_LOCK; otherwise, after STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
REQ-020 When locked_s=0 occurs on the final STABLE cycle, the drop SHALL win: go to WAIT_LOCK.
REQ-021 In RUN, locked_s=0 SHALL go to PLL_RESET on the next edge (sys_rst_n falls, pll_rst rises) and increment lock_lost_cnt.
REQ-022 Both event counters SHALL saturate at 255 and never wrap.
REQ-023 Counter width SHALL be sized for the largest of PLL_RST_CYCLES, STABLE_CYCLES and LOCK_TIMEOUT; the counter SHALL never wrap.

Reset
REQ-024 While rst_n=0, the block SHALL force: state PLL_RESET, pll_rst=1, sys_rst_n=0, counter=0, lock_lost_cnt=0, timeout_cnt=0, all synchronizer flops=0.
REQ-025 rst_n assertion mid-operation SHALL apply REQ-024 immediately, without waiting for a refclk edge, from any state.
REQ-026 After rst_n deasserts, the first PLL_RESET SHALL last exactly PLL_RST_CYCLES cycles.

Verification (SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32)
REQ-027 Release rst_n with pll_locked=1 held -> pll_rst=1 for 4 cycles; WAIT_LOCK; STABLE after the 2-cycle sync; sys_rst_n=1 after 8 further cycles; counters 0.
REQ-028 Hold pll_locked=0 for 100 cycles -> WAIT_LOCK times out after 32 cycles, pll_rst pulses 4 cycles, repeats; timeout_cnt=2 at cycle 100; sys_rst_n stays 0.
REQ-029 In STABLE, drop pll_locked for 1 cycle at count 5 -> WAIT_LOCK, then STABLE again; RUN only after a fresh 8-cycle run of lock.
REQ-030 In RUN, drop pll_locked -> after 2 sync cycles plus 1 edge, sys_rst_n=0, pll_rst=1, lock_lost_cnt=1; the full sequence repeats.
REQ-031 Force 260 lock-loss events -> lock_lost_cnt holds 255; all other behaviour unchanged.
REQ-032 Assert rst_n asynchronously mid-RUN and mid-STABLE -> outputs reach the REQ-024 values before the next refclk edge; counters read 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for a debounced lock, then releases sys_rst_n.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65535
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [1:0] state,
    output logic [7:0] lock_lost_cnt,
    output logic [7:0] timeout_cnt
);
    typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN} state_t;
    localparam int MAX_AB = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CW     = $clog2(MAX_C + 1);
    state_t                 st, nxt;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    assign locked_s = sync[SYNC_STAGES-1];
    assign state    = st;
    // Lock wins over timeout in WAIT_LOCK; a drop wins over completion in STABLE.
    always_comb begin
        nxt = st;
        case (st)
            PLL_RESET: nxt = (cnt == CW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RESET;
            WAIT_LOCK: nxt = locked_s ? STABLE : (cnt == CW'(LOCK_TIMEOUT - 1)) ? PLL_RESET : WAIT_LOCK;
            STABLE:    nxt = !locked_s ? WAIT_LOCK : (cnt == CW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
            default:   nxt = locked_s ? RUN : PLL_RESET;
        endcase
    end
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= PLL_RESET;
            cnt           <= '0;
            sync          <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            lock_lost_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], pll_locked};
            st        <= nxt;
            cnt       <= (nxt != st) ? '0 : (cnt == '1) ? cnt : cnt + CW'(1);
            pll_rst   <= (nxt == PLL_RESET);
            sys_rst_n <= (nxt == RUN);
            if (st == RUN && nxt == PLL_RESET && lock_lost_cnt != 8'hff)
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            if (st == WAIT_LOCK && nxt == PLL_RESET && timeout_cnt != 8'hff)
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed and randomized checks against a cycle-level reference model.
module tb_pll_lock_supervisor;
    localparam int SS = 2, PR = 4, SC = 8, LT = 32;
    logic       refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0;
    logic       pll_rst, sys_rst_n;
    logic [1:0] state;
    logic [7:0] lock_lost_cnt, timeout_cnt;
    logic [19:0] dut_vec;
    int errors = 0, checks = 0;
    int m_state, m_time, m_lcnt, m_tcnt;
    int m_q[SS];

    pll_lock_supervisor #(.SYNC_STAGES(SS), .PLL_RST_CYCLES(PR), .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT)) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n), .state(state), .lock_lost_cnt(lock_lost_cnt), .timeout_cnt(timeout_cnt)
    );

    always #10 refclk = ~refclk;
    assign dut_vec = {state, pll_rst, sys_rst_n, lock_lost_cnt, timeout_cnt};

    function automatic logic [19:0] exp_vec();
        return {2'(m_state), m_state == 0, m_state == 3, 8'(m_lcnt), 8'(m_tcnt)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_time = 0; m_lcnt = 0; m_tcnt = 0;
        for (int i = 0; i < SS; i++) m_q[i] = 0;
    endtask

    // Phases: 0 PLL reset, 1 waiting for lock, 2 lock qualifying, 3 running.
    task automatic model_edge(input logic lk);
        int ls, nx;
        ls = m_q[SS-1];
        nx = m_state;
        for (int i = SS - 1; i > 0; i--) m_q[i] = m_q[i-1];
        m_q[0] = int'(lk);
        case (m_state)
            0: if (m_time + 1 == PR) nx = 1;
            1: if (ls != 0) nx = 2;
               else if (m_time + 1 == LT) begin nx = 0; if (m_tcnt < 255) m_tcnt++; end
            2: if (ls == 0) nx = 1; else if (m_time + 1 == SC) nx = 3;
            default: if (ls == 0) begin nx = 0; if (m_lcnt < 255) m_lcnt++; end
        endcase
        m_time  = (nx != m_state) ? 0 : m_time + 1;
        m_state = nx;
    endtask

    task automatic step(input logic lk);
        pll_locked = lk;
        @(posedge refclk);
        model_edge(lk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        #3 rst_n = 1'b0;
        #2 model_reset();
        checks++;
        if (dut_vec !== 20'h20000) begin
            errors++;
            $display("FAIL %s_async: got %h want %h", tag, dut_vec, 20'h20000);
        end
        @(posedge refclk);
        #1 checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL %s_held: got %h want %h", tag, dut_vec, exp_vec());
        end
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pll_locked = 1'b1;
        repeat (2) @(posedge refclk);
        apply_reset("reset");
    endtask

    task automatic test_power_up();
        for (int n = 1; n <= 16; n++) begin
            step(1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL power_up_model c%0d: got %h want %h", n, dut_vec, exp_vec());
            end
            if (n == 3 || n == 4 || n == 5 || n == 12 || n == 13) begin
                checks++;
                if ((n == 3 && pll_rst !== 1'b1) || (n == 4 && (state !== 2'd1 || pll_rst !== 1'b0)) ||
                    (n == 5 && state !== 2'd2) || (n == 12 && sys_rst_n !== 1'b0) ||
                    (n == 13 && (state !== 2'd3 || sys_rst_n !== 1'b1))) begin
                    errors++;
                    $display("FAIL power_up_seq c%0d: got state=%0d pll_rst=%b sys_rst_n=%b", n, state, pll_rst, sys_rst_n);
                end
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset("timeout");
        for (int n = 1; n <= 100; n++) begin
            step(1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_model c%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (timeout_cnt !== 8'd2 || sys_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cnt: got %0d/%b want 2/0", timeout_cnt, sys_rst_n);
        end
    endtask

    task automatic test_stable_glitch();
        int n;
        apply_reset("glitch");
        n = 0;
        while (!(m_state == 2 && m_time == 5) && n < 60) begin
            step(1'b1);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_pre: got %h want %h", dut_vec, exp_vec());
            end
        end
        step(1'b0);
        n = 0;
        while (m_state != 3 && n < 60) begin
            step(1'b1);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_post: got %h want %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (n != 11 || state !== 2'd3) begin
            errors++;
            $display("FAIL glitch_run_delay: got %0d cycles state %0d want 11 cycles state 3", n, state);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        for (int k = 1; k <= 3; k++) begin
            step(1'b0);
            checks++;
            if (dut_vec !== exp_vec() || (k == 2 && sys_rst_n !== 1'b1) ||
                (k == 3 && {state, pll_rst, sys_rst_n, lock_lost_cnt} !== 12'h201)) begin
                errors++;
                $display("FAIL lock_loss k%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        n = 0;
        while (m_state != 3 && n < 60) begin
            step(1'b1);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL lock_loss_repeat: got %h want %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL lock_loss_rerun: got state %0d want 3", state);
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int e = 0; e < 260; e++) begin
            n = 0;
            while (m_state != 3 && n < 60) begin
                step(1'b1);
                n++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat_up e%0d: got %h want %h", e, dut_vec, exp_vec());
                end
            end
            n = 0;
            while (m_state != 0 && n < 10) begin
                step(1'b0);
                n++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat_down e%0d: got %h want %h", e, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (lock_lost_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_lock_lost: got %0d want 255", lock_lost_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (m_state != 3 && n < 60) begin step(1'b1); n++; end
        checks++;
        if (state !== 2'd3 || lock_lost_cnt !== 8'd255) begin
            errors++;
            $display("FAIL async_pre_run: got state %0d llc %0d want 3 255", state, lock_lost_cnt);
        end
        apply_reset("async_run");
        repeat (40) step(1'b0);
        n = 0;
        while (!(m_state == 2 && m_time == 3) && n < 60) begin step(1'b1); n++; end
        checks++;
        if (state !== 2'd2 || timeout_cnt === 8'd0) begin
            errors++;
            $display("FAIL async_pre_stable: got state %0d tc %0d want 2 nonzero", state, timeout_cnt);
        end
        apply_reset("async_stable");
    endtask

    task automatic test_random();
        logic lk;
        int run;
        lk = 1'b1;
        run = 0;
        for (int n = 0; n < 4000; n++) begin
            if (run == 0) begin
                lk = ($urandom_range(0, 3) != 0);
                run = lk ? $urandom_range(1, 30) : $urandom_range(1, 45);
            end
            run--;
            step(lk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_timeout();
        test_stable_glitch();
        test_lock_loss();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
